ahb_lite_reg8_bridge: RTL

- Generalised AHB-Lite slave front-end for 8-bit register peripherals, e.g. several UART16550 register cores, behind one HSEL.
- Decodes the channel and register index from HADDR and issues one-cycle read/write strobes to the selected channel.
- Wait states are parametrised per direction; misaligned-size or out-of-range accesses get a two-cycle ERROR response.
- Read strobes are exact single pulses, which is safe for FIFO-popping registers such as RBR.

---
 rtl/ahb_lite_reg8_bridge.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_reg8_bridge.sv
// AHB-Lite slave front-end fanning one HSEL out to NCH 8-bit register channels.
// Issues single-cycle read/write strobes with per-direction wait states and ERROR responses.
module ahb_lite_reg8_bridge #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned STRIDE_LOG2 = 2,
  parameter int unsigned WAIT_RD     = 0,
  parameter int unsigned WAIT_WR     = 0,
  parameter int unsigned LANE_MODE   = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [31:0]       HADDR,
  input  logic              HSEL,
  input  logic [2:0]        HSIZE,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic [NCH-1:0]    PSEL,
  output logic [REG_AW-1:0] PADDR,
  output logic [7:0]        PWDATA,
  output logic              PWE,
  output logic              PRE,
  input  logic [NCH*8-1:0]  PRDATA
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRWait = 3'd1;
  localparam logic [2:0] StRStb  = 3'd2;
  localparam logic [2:0] StRDone = 3'd3;
  localparam logic [2:0] StWWait = 3'd4;
  localparam logic [2:0] StErr1  = 3'd5;
  localparam logic [2:0] StErr2  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] reg_q, reg_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic [REG_AW-1:0] a_reg;
  logic [CHW-1:0]    a_ch;
  logic              a_err;
  logic              accept;
  logic              hready;
  logic [7:0]        rd_byte;
  logic [7:0]        wr_byte;

  assign a_reg  = HADDR[STRIDE_LOG2 +: REG_AW];
  assign a_ch   = HADDR[STRIDE_LOG2 + REG_AW +: CHW];
  assign a_err  = (32'(a_ch) >= NCH) || (HSIZE > 3'd2);
  assign accept = HSEL && HTRANS[1] && hready;

  assign wr_byte = (LANE_MODE != 0) ? HWDATA[{lane_q, 3'b000} +: 8] : HWDATA[7:0];

  // Sink for address/data bits outside the decoded fields.
  logic unused_bits;
  assign unused_bits = ^{HADDR, HTRANS[0], HWDATA};

  always_comb begin
    rd_byte = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch_q == CHW'(k)) rd_byte = PRDATA[8*k +: 8];
    end
  end

  always_comb begin
    hready = 1'b1;
    HRESP  = 1'b0;
    PRE    = 1'b0;
    PWE    = 1'b0;
    case (state_q)
      StRWait: hready = 1'b0;
      StRStb: begin
        hready = 1'b0;
        PRE    = 1'b1;
      end
      StWWait: begin
        hready = (cnt_q == 4'd0);
        PWE    = (cnt_q == 4'd0);
      end
      StErr1: begin
        hready = 1'b0;
        HRESP  = 1'b1;
      end
      StErr2:  HRESP = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    PSEL = '0;
    if (PRE || PWE) begin
      for (int unsigned k = 0; k < NCH; k++) PSEL[k] = (ch_q == CHW'(k));
    end
  end

  assign HREADY = hready;
  assign HRDATA = hrdata_q;
  assign PADDR  = (PRE || PWE) ? reg_q : '0;
  assign PWDATA = PWE ? wr_byte : 8'd0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reg_d    = reg_q;
    ch_d     = ch_q;
    lane_d   = lane_q;
    hrdata_d = hrdata_q;
    case (state_q)
      StRWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StRStb;
      end
      StRStb: begin
        hrdata_d = {4{rd_byte}};
        state_d  = StRDone;
      end
      StWWait: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = StIdle;
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
    // Acceptance is only possible in HREADY-high cycles, so it overrides the return to idle.
    if (accept) begin
      reg_d  = a_reg;
      ch_d   = a_ch;
      lane_d = HADDR[1:0];
      if (a_err) begin
        state_d = StErr1;
        cnt_d   = 4'd0;
      end else if (HWRITE) begin
        state_d = StWWait;
        cnt_d   = 4'(WAIT_WR);
      end else begin
        state_d = (WAIT_RD == 0) ? StRStb : StRWait;
        cnt_d   = 4'(WAIT_RD);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      reg_q    <= '0;
      ch_q     <= '0;
      lane_q   <= 2'd0;
      hrdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reg_q    <= reg_d;
      ch_q     <= ch_d;
      lane_q   <= lane_d;
      hrdata_q <= hrdata_d;
    end
  end

endmodule
